prco_mem_wb: RTL and testbench
==============================

Name: prco_mem_wb

Overview:
Memory/writeback stage of the PRCO core. It is the consumer end of the ALU output handshake: it takes the one-cycle ALU commit pulses (ce_reg / ce_ram) with result and branch flag. It then performs the register-file write, the data-RAM load/store, or the PC redirect, and signals completion back to pipeline control so fetch can resume.

Parameters:
DATA_W, 16, datapath width (result, RAM data, PC)
REG_ADDR_W, 3, register-file index width (8 GPRs)
RAM_RD_LAT, 1, data-RAM read latency in cycles (1..4), counted from the q_ram_re assert cycle

Ports:
i_clk  in  1  clock
i_reset_n  in  1  synchronous active-low reset
i_ce_reg  in  1  ALU commit pulse, register/branch path
i_ce_ram  in  1  ALU commit pulse, RAM path
i_op  in  5  opcode of committing instruction (PRCO_OP_* encoding)
i_rd  in  REG_ADDR_W  destination register index
i_result  in  DATA_W  ALU result (value, RAM address, or branch target)
i_store_data  in  DATA_W  data for SW
i_should_branch  in  1  ALU branch decision
q_reg_we  out  1  register-file write strobe
q_reg_addr  out  REG_ADDR_W  register-file write index
q_reg_data  out  DATA_W  register-file write data
q_ram_addr  out  DATA_W  data-RAM address
q_ram_re  out  1  data-RAM read strobe
q_ram_we  out  1  data-RAM write strobe
q_ram_din  out  DATA_W  data-RAM write data
i_ram_dout  in  DATA_W  data-RAM read data
q_pc_load  out  1  PC redirect strobe
q_pc_target  out  DATA_W  PC redirect value
q_done  out  1  one-cycle pulse, instruction retired
q_busy  out  1  stage occupied
q_err  out  1  sticky protocol error flag

Behaviour:
- Reset (i_reset_n=0 at posedge): state IDLE; every output 0; latency counter 0; q_err cleared. Reset mid-operation abandons the operation; no pending write completes.
- States: IDLE, REG_WB, RAM_RD, RAM_CAP, RAM_WR, DONE.
- IDLE, i_ce_ram=1: latch i_op/i_rd/i_result/i_store_data. LW -> RAM_RD. SW -> RAM_WR. Any other op -> DONE and set q_err.
- IDLE, i_ce_reg=1 (i_ce_ram=0): latch inputs -> REG_WB.
- i_ce_reg and i_ce_ram both 1: RAM path wins; q_err set.
- REG_WB (1 cycle):
  - MOV, MOVI, ADD, ADDI, SUBI, READ: q_reg_we=1, q_reg_addr=rd, q_reg_data=result.
  - JMP with should_branch=1: q_pc_load=1, q_pc_target=result; no register write. JMP with should_branch=0: no action.
  - CMP, NOP, WRITE, other ops: no write.
  - Next state DONE.
- RAM_RD: q_ram_re=1 and q_ram_addr=result for one cycle; counter loaded to RAM_RD_LAT-1 -> RAM_CAP.
- RAM_CAP: decrement counter each cycle. When counter==0, capture i_ram_dout into q_reg_data, assert q_reg_we with q_reg_addr=rd -> DONE. Total LW latency, commit to q_reg_we: RAM_RD_LAT+1 cycles.
- RAM_WR (1 cycle): q_ram_we=1, q_ram_addr=result, q_ram_din=store_data -> DONE.
- DONE: q_done=1 for exactly one cycle -> IDLE.
- All strobes (q_reg_we, q_ram_re, q_ram_we, q_pc_load, q_done) are single-cycle pulses. Data/address outputs hold their last value until the next operation.
- q_busy=1 in every state except IDLE.
- Commit pulse while q_busy=1: ignored, no state change, q_err set. q_err is cleared only by reset.
- Address is used unmodified (16-bit word address); no wrap or alignment checks.

Decomposition:
- Opcodes come from inc/prco_isa.v; no new opcodes.
- State encoding and the "op writes register" predicate as localparams/function in inc/prco_constants.v so pipeline control and debug share them.
- No sub-module needed; the latency counter stays inline.

Test Plan:
- ADDI commit: i_ce_reg=1, op=ADDI, rd=3, result=16'h0012 -> next cycle q_reg_we=1, addr=3, data=0012; q_done the cycle after.
- LW with RAM_RD_LAT=2: i_ce_ram=1, op=LW, result=16'h0040, RAM returns 16'hBEEF -> q_ram_re pulse at addr 0040; q_reg_we with BEEF 3 cycles after commit; q_done one cycle later.
- SW: i_ce_ram=1, op=SW, result=16'h0010, store_data=16'h1234 -> single q_ram_we pulse with addr 0010, din 1234; no q_reg_we.
- JMP taken vs not taken: result=16'h0020 with should_branch=1 -> q_pc_load=1, target 0020; repeat with should_branch=0 -> no q_pc_load; q_done in both cases.
- Overrun: second i_ce_reg while LW is in RAM_CAP -> ignored; q_err=1; LW completes normally.
- Reset mid-LW: deassert i_reset_n during RAM_CAP -> next cycle all outputs 0, q_busy=0, no q_reg_we.

Source files
------------

// File: rtl/prco_mem_wb_pkg.sv
// rtl/prco_mem_wb_pkg.sv - shared opcode encoding, stage states and writeback predicate
//
// Purpose: the single place that defines the PRCO_OP_* opcode encoding, the
//          state encoding of the memory/writeback stage, and the "op writes a
//          register" predicate. Pipeline control and debug logic import the
//          same definitions.
// Ports:   none (package).
package prco_mem_wb_pkg;

   localparam logic [4:0] PRCO_OP_NOP   = 5'h00;
   localparam logic [4:0] PRCO_OP_MOV   = 5'h01;
   localparam logic [4:0] PRCO_OP_MOVI  = 5'h02;
   localparam logic [4:0] PRCO_OP_ADD   = 5'h03;
   localparam logic [4:0] PRCO_OP_ADDI  = 5'h04;
   localparam logic [4:0] PRCO_OP_SUBI  = 5'h05;
   localparam logic [4:0] PRCO_OP_CMP   = 5'h06;
   localparam logic [4:0] PRCO_OP_JMP   = 5'h07;
   localparam logic [4:0] PRCO_OP_LW    = 5'h08;
   localparam logic [4:0] PRCO_OP_SW    = 5'h09;
   localparam logic [4:0] PRCO_OP_READ  = 5'h0A;
   localparam logic [4:0] PRCO_OP_WRITE = 5'h0B;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_REG_WB  = 3'd1,
      ST_RAM_RD  = 3'd2,
      ST_RAM_CAP = 3'd3,
      ST_RAM_WR  = 3'd4,
      ST_DONE    = 3'd5
   } wb_state_t;

   // Ops whose ALU result lands in the register file on the register path.
   function automatic logic op_writes_reg(input logic [4:0] op);
      case (op)
         PRCO_OP_MOV, PRCO_OP_MOVI, PRCO_OP_ADD,
         PRCO_OP_ADDI, PRCO_OP_SUBI, PRCO_OP_READ: op_writes_reg = 1'b1;
         default:                                  op_writes_reg = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/prco_mem_wb.sv
// rtl/prco_mem_wb.sv - PRCO memory/writeback stage (reg write, RAM load/store, PC redirect)
//
// Purpose: consumes the one-cycle ALU commit pulses and performs the register
//          write, data-RAM load/store or PC redirect, then pulses q_done.
// Ports:
//   i_clk, i_reset_n            clock, synchronous active-low reset
//   i_ce_reg, i_ce_ram          ALU commit pulses (register/branch path, RAM path)
//   i_op, i_rd, i_result        committing opcode, destination index, ALU result
//   i_store_data, i_should_branch  SW data, branch decision
//   q_reg_we/addr/data          register-file write port
//   q_ram_addr/re/we/din        data-RAM request, i_ram_dout read data
//   q_pc_load, q_pc_target      PC redirect
//   q_done, q_busy, q_err       retire pulse, stage occupied, sticky protocol error
module prco_mem_wb
   import prco_mem_wb_pkg::*;
#(
   parameter int DATA_W     = 16,
   parameter int REG_ADDR_W = 3,
   parameter int RAM_RD_LAT = 1
) (
   input  logic                  i_clk,
   input  logic                  i_reset_n,
   input  logic                  i_ce_reg,
   input  logic                  i_ce_ram,
   input  logic [4:0]            i_op,
   input  logic [REG_ADDR_W-1:0] i_rd,
   input  logic [DATA_W-1:0]     i_result,
   input  logic [DATA_W-1:0]     i_store_data,
   input  logic                  i_should_branch,
   output logic                  q_reg_we,
   output logic [REG_ADDR_W-1:0] q_reg_addr,
   output logic [DATA_W-1:0]     q_reg_data,
   output logic [DATA_W-1:0]     q_ram_addr,
   output logic                  q_ram_re,
   output logic                  q_ram_we,
   output logic [DATA_W-1:0]     q_ram_din,
   input  logic [DATA_W-1:0]     i_ram_dout,
   output logic                  q_pc_load,
   output logic [DATA_W-1:0]     q_pc_target,
   output logic                  q_done,
   output logic                  q_busy,
   output logic                  q_err
);

   wb_state_t         state, next_state;
   logic [4:0]        op_q;
   logic              branch_q;
   logic [1:0]        lat_cnt;
   logic [DATA_W-1:0] reg_data_q;
   logic              cap_now;

   // Final RAM_CAP cycle: read data is valid on i_ram_dout right now.
   assign cap_now = (state == ST_RAM_CAP) && (lat_cnt == 2'd0);

   always_comb begin
      next_state = state;
      case (state)
         ST_IDLE: begin
            if (i_ce_ram) begin
               if (i_op == PRCO_OP_LW)      next_state = ST_RAM_RD;
               else if (i_op == PRCO_OP_SW) next_state = ST_RAM_WR;
               else                         next_state = ST_DONE;
            end else if (i_ce_reg) begin
               next_state = ST_REG_WB;
            end
         end
         ST_REG_WB:  next_state = ST_DONE;
         ST_RAM_RD:  next_state = ST_RAM_CAP;
         ST_RAM_CAP: if (lat_cnt == 2'd0) next_state = ST_DONE;
         ST_RAM_WR:  next_state = ST_DONE;
         ST_DONE:    next_state = ST_IDLE;
         default:    next_state = ST_IDLE;
      endcase
   end

   // Strobes decode straight from state so each lasts exactly one state cycle.
   always_comb begin
      q_reg_we   = ((state == ST_REG_WB) && op_writes_reg(op_q)) || cap_now;
      q_ram_re   = (state == ST_RAM_RD);
      q_ram_we   = (state == ST_RAM_WR);
      q_pc_load  = (state == ST_REG_WB) && (op_q == PRCO_OP_JMP) && branch_q;
      q_done     = (state == ST_DONE);
      q_busy     = (state != ST_IDLE);
      // Load data is forwarded in the capture cycle and held afterwards.
      q_reg_data = cap_now ? i_ram_dout : reg_data_q;
   end

   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         state       <= ST_IDLE;
         op_q        <= PRCO_OP_NOP;
         branch_q    <= 1'b0;
         lat_cnt     <= 2'd0;
         reg_data_q  <= '0;
         q_reg_addr  <= '0;
         q_ram_addr  <= '0;
         q_ram_din   <= '0;
         q_pc_target <= '0;
         q_err       <= 1'b0;
      end else begin
         state <= next_state;
         if (state == ST_IDLE) begin
            if (i_ce_ram) begin
               op_q     <= i_op;
               branch_q <= 1'b0;
               if (i_ce_reg) q_err <= 1'b1;
               if (i_op == PRCO_OP_LW) begin
                  q_ram_addr <= i_result;
                  q_reg_addr <= i_rd;
               end else if (i_op == PRCO_OP_SW) begin
                  q_ram_addr <= i_result;
                  q_ram_din  <= i_store_data;
               end else begin
                  q_err <= 1'b1;
               end
            end else if (i_ce_reg) begin
               op_q     <= i_op;
               branch_q <= i_should_branch;
               if (op_writes_reg(i_op)) begin
                  q_reg_addr <= i_rd;
                  reg_data_q <= i_result;
               end
               if ((i_op == PRCO_OP_JMP) && i_should_branch)
                  q_pc_target <= i_result;
            end
         end else if (i_ce_reg || i_ce_ram) begin
            q_err <= 1'b1;
         end
         if (state == ST_RAM_RD)
            lat_cnt <= 2'(RAM_RD_LAT - 1);
         else if ((state == ST_RAM_CAP) && (lat_cnt != 2'd0))
            lat_cnt <= lat_cnt - 2'd1;
         if (cap_now)
            reg_data_q <= i_ram_dout;
      end
   end

endmodule

// File: tb/tb_prco_mem_wb.sv
// tb/tb_prco_mem_wb.sv - directed self-checking bench for prco_mem_wb
module tb_prco_mem_wb;
   import prco_mem_wb_pkg::*;

   logic        i_clk = 1'b0;
   logic        i_reset_n = 1'b0;
   logic        i_ce_reg = 1'b0, i_ce_ram = 1'b0;
   logic [4:0]  i_op = 5'd0;
   logic [2:0]  i_rd = 3'd0;
   logic [15:0] i_result = 16'h0, i_store_data = 16'h0;
   logic        i_should_branch = 1'b0;
   logic        q_reg_we, q_ram_re, q_ram_we, q_pc_load, q_done, q_busy, q_err;
   logic [2:0]  q_reg_addr;
   logic [15:0] q_reg_data, q_ram_addr, q_ram_din, q_pc_target;
   logic [15:0] i_ram_dout;
   logic        re_d1 = 1'b0, re_d2 = 1'b0;

   int tests = 0;
   int fails = 0;

   always #5 i_clk = ~i_clk;

   // RAM with 2-cycle read latency: data valid two cycles after the re cycle.
   always @(posedge i_clk) begin
      re_d1 <= q_ram_re;
      re_d2 <= re_d1;
   end
   assign i_ram_dout = re_d2 ? 16'hBEEF : 16'hDEAD;

   prco_mem_wb #(.DATA_W(16), .REG_ADDR_W(3), .RAM_RD_LAT(2)) dut (
      .i_clk(i_clk), .i_reset_n(i_reset_n),
      .i_ce_reg(i_ce_reg), .i_ce_ram(i_ce_ram),
      .i_op(i_op), .i_rd(i_rd), .i_result(i_result),
      .i_store_data(i_store_data), .i_should_branch(i_should_branch),
      .q_reg_we(q_reg_we), .q_reg_addr(q_reg_addr), .q_reg_data(q_reg_data),
      .q_ram_addr(q_ram_addr), .q_ram_re(q_ram_re), .q_ram_we(q_ram_we),
      .q_ram_din(q_ram_din), .i_ram_dout(i_ram_dout),
      .q_pc_load(q_pc_load), .q_pc_target(q_pc_target),
      .q_done(q_done), .q_busy(q_busy), .q_err(q_err)
   );

   // Drive one commit pulse; returns at the negedge of the cycle after commit.
   task automatic commit(input logic reg_p, input logic ram_p, input logic [4:0] op,
                         input logic [2:0] rd, input logic [15:0] res,
                         input logic [15:0] sd, input logic br);
      @(negedge i_clk);
      i_ce_reg = reg_p; i_ce_ram = ram_p; i_op = op; i_rd = rd;
      i_result = res; i_store_data = sd; i_should_branch = br;
      @(negedge i_clk);
      i_ce_reg = 1'b0; i_ce_ram = 1'b0;
   endtask

   task automatic test_reset;
      i_reset_n = 1'b0;
      repeat (2) @(negedge i_clk);
      tests++;
      if ({q_reg_we, q_ram_re, q_ram_we, q_pc_load, q_done, q_busy, q_err} !== 7'b0) begin
         $display("FAIL reset_strobes got=%b exp=0", {q_reg_we, q_ram_re, q_ram_we, q_pc_load, q_done, q_busy, q_err});
         fails++;
      end
      tests++;
      if ({q_reg_addr, q_reg_data, q_ram_addr, q_ram_din, q_pc_target} !== 67'b0) begin
         $display("FAIL reset_data got=%h exp=0", {q_reg_addr, q_reg_data, q_ram_addr, q_ram_din, q_pc_target});
         fails++;
      end
      i_reset_n = 1'b1;
   endtask

   task automatic test_addi;
      commit(1'b1, 1'b0, PRCO_OP_ADDI, 3'd3, 16'h0012, 16'h0, 1'b0);
      tests++;
      if ({q_reg_we, q_reg_addr, q_reg_data, q_busy, q_done} !== {1'b1, 3'd3, 16'h0012, 1'b1, 1'b0}) begin
         $display("FAIL addi_wb we=%b addr=%0d data=%h busy=%b done=%b exp we=1 addr=3 data=0012 busy=1 done=0",
                  q_reg_we, q_reg_addr, q_reg_data, q_busy, q_done);
         fails++;
      end
      @(negedge i_clk);
      tests++;
      if ({q_reg_we, q_done} !== 2'b01) begin
         $display("FAIL addi_done we=%b done=%b exp we=0 done=1", q_reg_we, q_done);
         fails++;
      end
      @(negedge i_clk);
      tests++;
      if ({q_done, q_busy, q_reg_data, q_err} !== {2'b00, 16'h0012, 1'b0}) begin
         $display("FAIL addi_idle done=%b busy=%b data=%h err=%b exp 0 0 0012 0", q_done, q_busy, q_reg_data, q_err);
         fails++;
      end
   endtask

   task automatic test_lw;
      commit(1'b0, 1'b1, PRCO_OP_LW, 3'd5, 16'h0040, 16'h0, 1'b0);
      tests++;
      if ({q_ram_re, q_ram_addr, q_reg_we} !== {1'b1, 16'h0040, 1'b0}) begin
         $display("FAIL lw_re re=%b addr=%h we=%b exp re=1 addr=0040 we=0", q_ram_re, q_ram_addr, q_reg_we);
         fails++;
      end
      @(negedge i_clk);
      tests++;
      if ({q_ram_re, q_reg_we, q_done} !== 3'b000) begin
         $display("FAIL lw_wait re=%b we=%b done=%b exp 000", q_ram_re, q_reg_we, q_done);
         fails++;
      end
      @(negedge i_clk);
      tests++;
      if ({q_reg_we, q_reg_addr, q_reg_data, q_done} !== {1'b1, 3'd5, 16'hBEEF, 1'b0}) begin
         $display("FAIL lw_wb we=%b addr=%0d data=%h done=%b exp we=1 addr=5 data=BEEF done=0",
                  q_reg_we, q_reg_addr, q_reg_data, q_done);
         fails++;
      end
      @(negedge i_clk);
      tests++;
      if ({q_reg_we, q_done, q_reg_data} !== {2'b01, 16'hBEEF}) begin
         $display("FAIL lw_done we=%b done=%b data=%h exp we=0 done=1 data=BEEF", q_reg_we, q_done, q_reg_data);
         fails++;
      end
      @(negedge i_clk);
      tests++;
      if ({q_busy, q_err} !== 2'b00) begin
         $display("FAIL lw_idle busy=%b err=%b exp 00", q_busy, q_err);
         fails++;
      end
   endtask

   task automatic test_sw;
      commit(1'b0, 1'b1, PRCO_OP_SW, 3'd2, 16'h0010, 16'h1234, 1'b0);
      tests++;
      if ({q_ram_we, q_ram_addr, q_ram_din, q_reg_we, q_ram_re} !== {1'b1, 16'h0010, 16'h1234, 2'b00}) begin
         $display("FAIL sw_wr we=%b addr=%h din=%h reg_we=%b re=%b exp 1 0010 1234 0 0",
                  q_ram_we, q_ram_addr, q_ram_din, q_reg_we, q_ram_re);
         fails++;
      end
      @(negedge i_clk);
      tests++;
      if ({q_ram_we, q_reg_we, q_done, q_ram_din} !== {3'b001, 16'h1234}) begin
         $display("FAIL sw_done ram_we=%b reg_we=%b done=%b din=%h exp 0 0 1 1234", q_ram_we, q_reg_we, q_done, q_ram_din);
         fails++;
      end
      @(negedge i_clk);
   endtask

   task automatic test_jmp;
      commit(1'b1, 1'b0, PRCO_OP_JMP, 3'd1, 16'h0020, 16'h0, 1'b1);
      tests++;
      if ({q_pc_load, q_pc_target, q_reg_we} !== {1'b1, 16'h0020, 1'b0}) begin
         $display("FAIL jmp_taken load=%b target=%h reg_we=%b exp 1 0020 0", q_pc_load, q_pc_target, q_reg_we);
         fails++;
      end
      @(negedge i_clk);
      tests++;
      if ({q_pc_load, q_done} !== 2'b01) begin
         $display("FAIL jmp_taken_done load=%b done=%b exp 0 1", q_pc_load, q_done);
         fails++;
      end
      @(negedge i_clk);
      commit(1'b1, 1'b0, PRCO_OP_JMP, 3'd1, 16'h0030, 16'h0, 1'b0);
      tests++;
      if ({q_pc_load, q_pc_target, q_reg_we, q_busy} !== {1'b0, 16'h0020, 1'b0, 1'b1}) begin
         $display("FAIL jmp_not_taken load=%b target=%h reg_we=%b busy=%b exp 0 0020 0 1",
                  q_pc_load, q_pc_target, q_reg_we, q_busy);
         fails++;
      end
      @(negedge i_clk);
      tests++;
      if (q_done !== 1'b1) begin
         $display("FAIL jmp_not_taken_done done=%b exp 1", q_done);
         fails++;
      end
      @(negedge i_clk);
   endtask

   task automatic test_overrun;
      tests++;
      if (q_err !== 1'b0) begin
         $display("FAIL overrun_pre err=%b exp 0", q_err);
         fails++;
      end
      commit(1'b0, 1'b1, PRCO_OP_LW, 3'd6, 16'h0044, 16'h0, 1'b0);
      @(negedge i_clk);
      i_ce_reg = 1'b1; i_op = PRCO_OP_ADDI; i_rd = 3'd1; i_result = 16'h0077;
      @(negedge i_clk);
      i_ce_reg = 1'b0;
      tests++;
      if ({q_reg_we, q_reg_addr, q_reg_data, q_err} !== {1'b1, 3'd6, 16'hBEEF, 1'b1}) begin
         $display("FAIL overrun_wb we=%b addr=%0d data=%h err=%b exp 1 6 BEEF 1",
                  q_reg_we, q_reg_addr, q_reg_data, q_err);
         fails++;
      end
      @(negedge i_clk);
      tests++;
      if ({q_done, q_reg_we} !== 2'b10) begin
         $display("FAIL overrun_done done=%b we=%b exp 1 0", q_done, q_reg_we);
         fails++;
      end
      @(negedge i_clk);
      tests++;
      if ({q_busy, q_reg_we, q_err, q_reg_data} !== {3'b001, 16'hBEEF}) begin
         $display("FAIL overrun_idle busy=%b we=%b err=%b data=%h exp 0 0 1 BEEF", q_busy, q_reg_we, q_err, q_reg_data);
         fails++;
      end
   endtask

   task automatic test_bad_ram_op;
      commit(1'b1, 1'b1, PRCO_OP_ADDI, 3'd4, 16'h0099, 16'h0, 1'b0);
      tests++;
      if ({q_done, q_reg_we, q_ram_re, q_ram_we, q_err} !== 5'b10001) begin
         $display("FAIL bad_ram_op done=%b we=%b re=%b ram_we=%b err=%b exp 1 0 0 0 1",
                  q_done, q_reg_we, q_ram_re, q_ram_we, q_err);
         fails++;
      end
      @(negedge i_clk);
   endtask

   task automatic test_reset_mid_lw;
      commit(1'b0, 1'b1, PRCO_OP_LW, 3'd7, 16'h0050, 16'h0, 1'b0);
      @(negedge i_clk);
      i_reset_n = 1'b0;
      @(negedge i_clk);
      i_reset_n = 1'b1;
      tests++;
      if ({q_reg_we, q_ram_re, q_ram_we, q_pc_load, q_done, q_busy, q_err} !== 7'b0) begin
         $display("FAIL reset_mid_strobes got=%b exp=0", {q_reg_we, q_ram_re, q_ram_we, q_pc_load, q_done, q_busy, q_err});
         fails++;
      end
      tests++;
      if ({q_reg_addr, q_reg_data, q_ram_addr} !== 35'b0) begin
         $display("FAIL reset_mid_data got=%h exp=0", {q_reg_addr, q_reg_data, q_ram_addr});
         fails++;
      end
      @(negedge i_clk);
      tests++;
      if ({q_reg_we, q_busy, q_done} !== 3'b000) begin
         $display("FAIL reset_mid_after we=%b busy=%b done=%b exp 000", q_reg_we, q_busy, q_done);
         fails++;
      end
   endtask

   initial begin
      test_reset();
      test_addi();
      test_lw();
      test_sw();
      test_jmp();
      test_overrun();
      test_reset();
      test_bad_ram_op();
      test_reset();
      test_reset_mid_lw();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
